macro_counter_incr: RTL and testbench

- Parametrised, registered successor to the 2-bit combinational increment ROM.
- Holds a WIDTH-bit count with a programmable modulo and wrap or saturate mode.
- Provides synchronous clear and load, plus a carry pulse and a sticky overflow flag.
- General-purpose utility for the core and SoC: beat counters, retry counters, pointer generation.

---
 rtl/macro_util_pkg.sv | 24 ++
 rtl/macro_incr.sv | 15 +
 rtl/macro_counter_incr.sv | 98 +++++++++
 tb/tb_macro_counter_incr.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/macro_util_pkg.sv
// Shared helpers for the macro counter family.
//   clog2      : ceiling log2 for sizing, at least 1
//   calc_last  : highest count value for a given WIDTH/MODULO (MODULO=0 -> 2^WIDTH)
//   MODE_*     : values for the SATURATE parameter
package macro_util_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  function automatic int clog2(input longint unsigned n);
    int r;
    r = 0;
    while ((longint'(1) << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // A width of 64 makes the shift produce 0, and the subtraction then
  // wraps to all ones, which is the correct LAST for a full 64-bit range.
  function automatic longint unsigned calc_last(input int width, input int modulo);
    if (modulo == 0) return (64'd1 << width) - 64'd1;
    else             return 64'(modulo) - 64'd1;
  endfunction

endpackage

// File: rtl/macro_incr.sv
// Combinational WIDTH-bit incrementer; the general form of the old 2-bit ROM.
//   d : operand
//   q : d + 1, truncated to WIDTH
//   c : carry-out of the WIDTH+1 bit sum (set only when d is all ones)
module macro_incr #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             c
);

  assign {c, q} = {1'b0, d} + (WIDTH+1)'(1);

endmodule

// File: rtl/macro_counter_incr.sv
// Registered modulo counter with wrap/saturate mode, carry pulse and sticky
// overflow.
//   clk, resetn    : clock, async active-low reset
//   i_clear        : sync clear to 0 (highest priority)
//   i_load         : sync load of i_load_value, clamped to LAST
//   i_en           : increment request
//   o_value        : registered count
//   o_terminal     : o_value == LAST (combinational)
//   o_carry        : one-cycle pulse after an increment attempted at LAST
//   o_overflow     : sticky version of o_carry, cleared by clear/load
module macro_counter_incr
  import macro_util_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MODULO      = 0,
  parameter int SATURATE    = MODE_WRAP,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_value,
  output logic             o_terminal,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(calc_last(WIDTH, MODULO));
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  if (WIDTH < 1) begin : g_bad_width
    $error("macro_counter_incr: WIDTH must be >= 1");
  end
  if (MODULO != 0 && (MODULO < 2 || (WIDTH < 31 && MODULO > (1 << WIDTH)))) begin : g_bad_mod
    $error("macro_counter_incr: MODULO out of range");
  end
  if (RESET_VALUE < 0 || longint'(RESET_VALUE) > longint'(calc_last(WIDTH, MODULO))) begin : g_bad_rst
    $error("macro_counter_incr: RESET_VALUE exceeds LAST");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_d, ovf_d;
  logic [WIDTH-1:0] inc_q;
  logic             inc_c;
  logic             at_last;
  logic             wrap;

  macro_incr #(.WIDTH(WIDTH)) u_incr (
    .d (cnt_q),
    .q (inc_q),
    .c (inc_c)
  );

  assign at_last = (cnt_q == LAST);
  // Full power-of-two range: the natural carry-out is the wrap. With a
  // modulo the raw carry would fire at the wrong value, so use the compare.
  assign wrap    = (MODULO == 0) ? inc_c : at_last;

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    ovf_d   = o_overflow;
    if (i_clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (i_load) begin
      cnt_d = (i_load_value > LAST) ? LAST : i_load_value;
      ovf_d = 1'b0;
    end else if (i_en) begin
      if (wrap) begin
        cnt_d   = (SATURATE == MODE_SATURATE) ? LAST : '0;
        carry_d = 1'b1;
        ovf_d   = 1'b1;
      end else begin
        cnt_d = inc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= RST_V;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      o_carry    <= carry_d;
      o_overflow <= ovf_d;
    end
  end

  assign o_value    = cnt_q;
  assign o_terminal = at_last;

endmodule

// File: tb/tb_macro_counter_incr.sv
// Directed bench for macro_counter_incr across four parameter sets sharing
// one stimulus bus:
//   a : W=2  MOD=0  wrap
//   b : W=4  MOD=10 wrap
//   c : W=4  MOD=10 saturate
//   d : W=4  MOD=0  wrap, RESET_VALUE=3
module tb_macro_counter_incr;

  logic       clk, resetn, clear, load, en;
  logic [3:0] lv;

  logic [1:0] a_val; logic a_term, a_carry, a_ovf;
  logic [3:0] b_val; logic b_term, b_carry, b_ovf;
  logic [3:0] c_val; logic c_term, c_carry, c_ovf;
  logic [3:0] d_val; logic d_term, d_carry, d_ovf;

  int errors = 0;
  int checks = 0;

  macro_counter_incr #(.WIDTH(2), .MODULO(0), .SATURATE(0), .RESET_VALUE(0)) dut_a (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_load(load), .i_load_value(lv[1:0]),
    .i_en(en), .o_value(a_val), .o_terminal(a_term), .o_carry(a_carry), .o_overflow(a_ovf));
  macro_counter_incr #(.WIDTH(4), .MODULO(10), .SATURATE(0), .RESET_VALUE(0)) dut_b (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_load(load), .i_load_value(lv),
    .i_en(en), .o_value(b_val), .o_terminal(b_term), .o_carry(b_carry), .o_overflow(b_ovf));
  macro_counter_incr #(.WIDTH(4), .MODULO(10), .SATURATE(1), .RESET_VALUE(0)) dut_c (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_load(load), .i_load_value(lv),
    .i_en(en), .o_value(c_val), .o_terminal(c_term), .o_carry(c_carry), .o_overflow(c_ovf));
  macro_counter_incr #(.WIDTH(4), .MODULO(0), .SATURATE(0), .RESET_VALUE(3)) dut_d (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_load(load), .i_load_value(lv),
    .i_en(en), .o_value(d_val), .o_terminal(d_term), .o_carry(d_carry), .o_overflow(d_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    resetn = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0; lv = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_val !== 2'd0 || a_carry !== 1'b0 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_a: val=%0d carry=%b ovf=%b, want 0 0 0", a_val, a_carry, a_ovf); end
    checks++; if (c_val !== 4'd0 || c_carry !== 1'b0 || c_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_c: val=%0d carry=%b ovf=%b, want 0 0 0", c_val, c_carry, c_ovf); end
    checks++; if (d_val !== 4'd3 || d_carry !== 1'b0 || d_ovf !== 1'b0 || d_term !== 1'b0) begin
      errors++; $display("FAIL reset_d: val=%0d carry=%b ovf=%b term=%b, want 3 0 0 0", d_val, d_carry, d_ovf, d_term); end
  endtask

  task automatic test_wrap_w2();
    logic [1:0] ev [5];
    logic       ec [5];
    logic       eo [5];
    logic       et [5];
    ev = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ec = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    et = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    checks++; if (a_term !== 1'b0) begin
      errors++; $display("FAIL w2_term0: term=%b, want 0", a_term); end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (a_val !== ev[k] || a_carry !== ec[k] || a_ovf !== eo[k] || a_term !== et[k]) begin
        errors++;
        $display("FAIL w2_step%0d: val=%0d carry=%b ovf=%b term=%b, want %0d %b %b %b",
                 k, a_val, a_carry, a_ovf, a_term, ev[k], ec[k], eo[k], et[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_modulo_wrap();
    logic [3:0] ev [3];
    logic       ec [3];
    logic       eo [3];
    ev = '{4'd9, 4'd0, 4'd1};
    ec = '{1'b0, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b1};
    do_reset();
    load = 1'b1; lv = 4'd8;
    @(negedge clk);
    load = 1'b0;
    checks++; if (b_val !== 4'd8 || b_carry !== 1'b0 || b_term !== 1'b0) begin
      errors++; $display("FAIL mod_load8: val=%0d carry=%b term=%b, want 8 0 0", b_val, b_carry, b_term); end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (b_val !== ev[k] || b_carry !== ec[k] || b_ovf !== eo[k]) begin
        errors++;
        $display("FAIL mod_step%0d: val=%0d carry=%b ovf=%b, want %0d %b %b",
                 k, b_val, b_carry, b_ovf, ev[k], ec[k], eo[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    load = 1'b1; lv = 4'd12;
    @(negedge clk);
    load = 1'b0;
    checks++; if (c_val !== 4'd9 || c_term !== 1'b1 || c_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_clamp: val=%0d term=%b ovf=%b, want 9 1 0", c_val, c_term, c_ovf); end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (c_val !== 4'd9 || c_carry !== 1'b1 || c_ovf !== 1'b1) begin
        errors++; $display("FAIL sat_hold%0d: val=%0d carry=%b ovf=%b, want 9 1 1", k, c_val, c_carry, c_ovf); end
    end
    en = 1'b0;
    @(negedge clk);
    checks++; if (c_val !== 4'd9 || c_carry !== 1'b0 || c_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_idle: val=%0d carry=%b ovf=%b, want 9 0 1", c_val, c_carry, c_ovf); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (c_val !== 4'd0 || c_carry !== 1'b0 || c_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_clear: val=%0d carry=%b ovf=%b, want 0 0 0", c_val, c_carry, c_ovf); end
  endtask

  task automatic test_priority();
    do_reset();
    load = 1'b1; lv = 4'd9;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    checks++; if (b_val !== 4'd0 || b_carry !== 1'b1 || b_ovf !== 1'b1) begin
      errors++; $display("FAIL pri_wrap: val=%0d carry=%b ovf=%b, want 0 1 1", b_val, b_carry, b_ovf); end
    load = 1'b1; lv = 4'd9;
    @(negedge clk);
    load = 1'b0;
    checks++; if (b_val !== 4'd9 || b_ovf !== 1'b0 || b_carry !== 1'b0) begin
      errors++; $display("FAIL pri_load_clr_ovf: val=%0d ovf=%b carry=%b, want 9 0 0", b_val, b_ovf, b_carry); end
    clear = 1'b1; load = 1'b1; lv = 4'd5; en = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (b_val !== 4'd0 || b_carry !== 1'b0 || b_ovf !== 1'b0) begin
      errors++; $display("FAIL pri_clear_wins: val=%0d carry=%b ovf=%b, want 0 0 0", b_val, b_carry, b_ovf); end
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    checks++; if (b_val !== 4'd5 || b_carry !== 1'b0 || b_ovf !== 1'b0) begin
      errors++; $display("FAIL pri_load_wins: val=%0d carry=%b ovf=%b, want 5 0 0", b_val, b_carry, b_ovf); end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    load = 1'b1; lv = 4'd15;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    @(negedge clk);
    checks++; if (d_val !== 4'd0 || d_carry !== 1'b1 || d_ovf !== 1'b1) begin
      errors++; $display("FAIL rst_wrap: val=%0d carry=%b ovf=%b, want 0 1 1", d_val, d_carry, d_ovf); end
    repeat (7) @(negedge clk);
    en = 1'b0;
    checks++; if (d_val !== 4'd7 || d_carry !== 1'b0 || d_ovf !== 1'b1) begin
      errors++; $display("FAIL rst_count7: val=%0d carry=%b ovf=%b, want 7 0 1", d_val, d_carry, d_ovf); end
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++; if (d_val !== 4'd3 || d_carry !== 1'b0 || d_ovf !== 1'b0) begin
      errors++; $display("FAIL rst_async: val=%0d carry=%b ovf=%b, want 3 0 0", d_val, d_carry, d_ovf); end
    @(negedge clk);
    resetn = 1'b1; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    checks++; if (d_val !== 4'd4 || d_carry !== 1'b0) begin
      errors++; $display("FAIL rst_release_inc: val=%0d carry=%b, want 4 0", d_val, d_carry); end
  endtask

  initial begin
    test_reset();
    test_wrap_w2();
    test_modulo_wrap();
    test_saturate();
    test_priority();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
